uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//   Consumes bytes from the TX FIFO's valid/ready output and serialises each as an async UART frame on tx_o.
//   Frame: start bit, 5-8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
//   Sits between the TX io_generic_fifo (data_o/valid_o/ready_i) and the UART TX pad.
//   frame_done_o feeds the APB interrupt/status logic.
// PARAMETERS
//   DIV_WIDTH   16   width of the bit-period divisor
// PORTS
//   clk_i            in   1          system clock
//   rst_i            in   1          reset; synchronous, active-high
//   cfg_div_i        in   DIV_WIDTH  bit period = cfg_div_i+1 clk_i cycles (0 => 1 cycle/bit)
//   cfg_bits_i       in   2          data bits: 00=5, 01=6, 10=7, 11=8
//   cfg_parity_en_i  in   1          1 = append parity bit
//   cfg_parity_odd_i in   1          0 = even parity, 1 = odd parity
//   cfg_stop2_i      in   1          0 = 1 stop bit, 1 = 2 stop bits
//   data_i           in   8          byte from FIFO data_o
//   valid_i          in   1          FIFO valid_o
//   ready_o          out  1          to FIFO ready_i; byte accepted when valid_i && ready_o
//   tx_o             out  1          serial line, idle high; registered
//   busy_o           out  1          1 while a frame is in progress
//   frame_done_o     out  1          1-cycle pulse in the last cycle of the final stop bit
// BEHAVIOUR
//   States: IDLE, START, DATA, PARITY, STOP.
//   - Bit counter cnt counts 0..div_q; a bit ends when cnt==div_q.
//   - Bit index idx counts data bits and stop bits.
//   Reset (rst_i sampled high at posedge): next state IDLE, tx_o=1, cnt=0, idx=0.
//   - ready_o=0, busy_o=0, frame_done_o=0 while rst_i is high.
//   - Reset mid-frame aborts the frame: tx_o=1 from the next cycle; the byte is lost.
//   Accept: at the edge where valid_i && ready_o:
//   - Latch data_i, cfg_bits_i, cfg_parity_en_i, cfg_parity_odd_i, cfg_stop2_i and cfg_div_i (div_q).
//   - Go to START, tx_o<=0, cnt<=0.
//   - Config or data changes after accept do not affect the frame in flight.
//   START: tx_o=0 for div_q+1 cycles, then DATA with idx=0.
//   DATA: tx_o=data_q[idx] for div_q+1 cycles per bit, for N = 5+bits_q bits.
//   - After the last bit, go to PARITY if parity_en_q, else STOP.
//   - Data bits at positions >= N are ignored.
//   PARITY: bit = ^(data_q[N-1:0]) ^ parity_odd_q, held for div_q+1 cycles.
//   STOP: tx_o=1 for S*(div_q+1) cycles, S = 1 + stop2_q.
//   ready_o = (state==IDLE) || (state==STOP && last stop bit && cnt==div_q). Combinational; no dependency on valid_i.
//   Back-to-back: an accept in the last STOP cycle goes directly to START, with no idle gap.
//   - Frame period = (1+N+P+S)*(div_q+1) cycles, P = parity_en_q.
//   - With no accept in that cycle, go to IDLE; tx_o stays 1.
//   busy_o = (state != IDLE).
//   frame_done_o = 1 exactly in the cycle where STOP ends (last stop bit, cnt==div_q). Asserted whether or not a new byte is accepted.
//   Latency: accept at edge k; tx_o falls at edge k, so it is low in cycle k+1.
//   cfg_div_i=0: every bit lasts exactly 1 cycle; all rules above still hold.
//   Counter arithmetic is unsigned in DIV_WIDTH bits. cnt never exceeds div_q and never wraps.
// TESTING
//   1. div=3, 8N1, send 0x55.
//      -> tx_o = 0,1,0,1,0,1,0,1,0,1 (start, b0..b7, stop), 4 cycles each.
//      -> frame_done_o pulses once at cycle 40; ready_o high again in that same cycle.
//   2. div=1, 7E1, send 0x41 -> data 1,0,0,0,0,0,1; parity 0; 1 stop; frame = 20 cycles.
//      Repeat with odd parity -> parity bit 1.
//   3. div=0, 5O2, send 0xE7 -> data 1,1,1,0,0 (bits 7:5 ignored); parity 0; stop 1,1; frame = 9 cycles.
//   4. div=0, 8N2, FIFO holds 0xA5,0x3C with valid_i held high.
//      -> start edges exactly 11 cycles apart; tx_o never idles between frames.
//      -> ready_o high for exactly 1 cycle per frame.
//   5. div=7, 8N1, send 0xFF; pulse rst_i for 1 cycle during bit 3.
//      -> tx_o=1, busy_o=0 the next cycle.
//      -> a subsequent 0x00 frame is correct (9 low bits of 8 cycles, then stop).
//   6. Change cfg_div_i from 3 to 9 and cfg_bits_i mid-frame.
//      -> current frame keeps div=3 and 8 bits.
//      -> the next accepted frame uses the new values.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART TX serialiser: FIFO byte -> start, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Latency: byte accepted at edge k drives the start bit (tx_o low) from cycle k+1; tx_o is registered.
// Backpressure: ready_o high only when idle or in the final cycle of the last stop bit (back-to-back frames).
module uart_tx_serializer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic [1:0]           cfg_bits_i,
    input  logic                 cfg_parity_en_i,
    input  logic                 cfg_parity_odd_i,
    input  logic                 cfg_stop2_i,
    input  logic [7:0]           data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 frame_done_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [DIV_WIDTH-1:0] CNT_ONE = 1;

    logic [2:0]           r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [2:0]           r_idx;
    logic                 r_tx;

    // Per-frame snapshot so config/data changes never disturb a frame in flight
    logic [7:0]           r_data;
    logic [1:0]           r_bits;
    logic                 r_par_en;
    logic                 r_par_odd;
    logic                 r_stop2;
    logic [DIV_WIDTH-1:0] r_div;

    logic       w_bit_end;
    logic       w_last_data;
    logic       w_last_stop;
    logic       w_stop_end;
    logic       w_ready;
    logic       w_accept;
    logic [7:0] w_mask;
    logic       w_parity;
    logic       w_next_bit;

    assign w_bit_end   = (r_cnt == r_div);
    assign w_last_data = (r_idx == (3'd4 + {1'b0, r_bits}));
    assign w_last_stop = (r_idx == {2'b00, r_stop2});
    assign w_stop_end  = (r_state == S_STOP) && w_last_stop && w_bit_end;
    assign w_ready     = !rst_i && ((r_state == S_IDLE) || w_stop_end);
    assign w_accept    = valid_i && w_ready;
    // Bits above the configured width must not contribute to parity
    assign w_mask      = 8'hFF >> (2'd3 - r_bits);
    assign w_parity    = (^(r_data & w_mask)) ^ r_par_odd;
    assign w_next_bit  = r_data[r_idx + 3'd1];

    assign ready_o      = w_ready;
    assign tx_o         = r_tx;
    assign busy_o       = !rst_i && (r_state != S_IDLE);
    assign frame_done_o = !rst_i && w_stop_end;

    // Snapshot byte and line configuration on every accepted handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data    <= 8'h00;
            r_bits    <= 2'b00;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_stop2   <= 1'b0;
            r_div     <= '0;
        end else if (w_accept) begin
            r_data    <= data_i;
            r_bits    <= cfg_bits_i;
            r_par_en  <= cfg_parity_en_i;
            r_par_odd <= cfg_parity_odd_i;
            r_stop2   <= cfg_stop2_i;
            r_div     <= cfg_div_i;
        end
    end

    // Frame sequencer: bit timing, bit index and the registered line level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                        r_idx   <= 3'd0;
                        r_tx    <= r_data[0];
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_last_data) begin
                            r_idx <= 3'd0;
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                r_tx    <= w_parity;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            r_tx  <= w_next_bit;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_cnt   <= '0;
                        r_idx   <= 3'd0;
                        r_tx    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_last_stop) begin
                            r_idx <= 3'd0;
                            if (w_accept) begin
                                r_state <= S_START;
                                r_tx    <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_idx   <= 3'd0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: per-cycle expected line waveform queued at each accept.
// Monitor compares tx_o/busy_o/ready_o/frame_done_o every cycle; tasks check frame timing.
// Inputs change 1 time unit after posedge; outputs sampled on negedge.
module tb_uart_tx_serializer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] cfg_div_i = 16'd0;
    logic [1:0]  cfg_bits_i = 2'b11;
    logic        cfg_parity_en_i = 1'b0;
    logic        cfg_parity_odd_i = 1'b0;
    logic        cfg_stop2_i = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        tx_o;
    logic        busy_o;
    logic        frame_done_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    logic exp_q[$];
    logic last_q[$];

    uart_tx_serializer #(.DIV_WIDTH(16)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cfg_div_i        (cfg_div_i),
        .cfg_bits_i       (cfg_bits_i),
        .cfg_parity_en_i  (cfg_parity_en_i),
        .cfg_parity_odd_i (cfg_parity_odd_i),
        .cfg_stop2_i      (cfg_stop2_i),
        .data_i           (data_i),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .tx_o             (tx_o),
        .busy_o           (busy_o),
        .frame_done_o     (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Expected line level per cycle for one frame, appended to the scoreboard
    task automatic push_frame(input logic [7:0] d, input int div, input int nb,
                              input bit pe, input bit po, input bit s2);
        logic bits[$];
        logic p;
        p = po;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(d[i]);
            p = p ^ d[i];
        end
        if (pe) bits.push_back(p);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c <= div; c++) begin
                exp_q.push_back(bits[b]);
                last_q.push_back((b == bits.size() - 1) && (c == div));
            end
        end
    endtask

    always @(posedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
            last_q.delete();
        end else if (valid_i && ready_o) begin
            push_frame(data_i, int'(cfg_div_i), 5 + int'(cfg_bits_i),
                       cfg_parity_en_i, cfg_parity_odd_i, cfg_stop2_i);
        end
    end

    always @(negedge clk_i) begin
        logic e, l, eb;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                l = last_q.pop_front();
                eb = 1'b1;
            end else begin
                e = 1'b1;
                l = 1'b0;
                eb = 1'b0;
            end
            if (rst_i) begin
                l = 1'b0;
                eb = 1'b0;
            end
            total++;
            if (tx_o !== e) begin
                bad++;
                $display("FAIL tx_wave cyc=%0d got=%b want=%b", cyc, tx_o, e);
            end
            total++;
            if (busy_o !== eb) begin
                bad++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy_o, eb);
            end
            total++;
            if (frame_done_o !== l) begin
                bad++;
                $display("FAIL frame_done cyc=%0d got=%b want=%b", cyc, frame_done_o, l);
            end
            total++;
            if (ready_o !== (!rst_i && (!eb || l))) begin
                bad++;
                $display("FAIL ready cyc=%0d got=%b want=%b", cyc, ready_o, (!rst_i && (!eb || l)));
            end
        end
    end

    // Present one byte and hold valid until the handshake edge; acc = cycle of first start-bit cycle
    task automatic send(input logic [7:0] d, input int div, input logic [1:0] nb,
                        input bit pe, input bit po, input bit s2, output int acc);
        bit got;
        got = 1'b0;
        @(posedge clk_i); #1;
        data_i = d;
        cfg_div_i = 16'(div);
        cfg_bits_i = nb;
        cfg_parity_en_i = pe;
        cfg_parity_odd_i = po;
        cfg_stop2_i = s2;
        valid_i = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_i);
            if (ready_o) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        acc = cyc;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL send_timeout got=no_ready want=ready");
        end
    endtask

    // Run until the line returns to idle, collecting frame_done pulses
    task automatic wait_frame(output int fd_cnt, output int fd_cyc, output bit ok);
        fd_cnt = 0;
        fd_cyc = -1;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_i);
            if (frame_done_o) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (!busy_o && fd_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        total++;
        if (tx_o !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx_o); end
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        total++;
        if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready_o); end
        total++;
        if (frame_done_o !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", frame_done_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (ready_o !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", ready_o); end
        mon_en = 1'b1;
    endtask

    task automatic test_frame(input logic [7:0] d, input int div, input logic [1:0] nb,
                              input bit pe, input bit po, input bit s2, input int exp_len);
        int acc, fd_cnt, fd_cyc;
        bit ok;
        send(d, div, nb, pe, po, s2, acc);
        wait_frame(fd_cnt, fd_cyc, ok);
        total++;
        if (!ok || fd_cnt != 1) begin
            bad++;
            $display("FAIL frame_%h_done_count got=%0d want=1", d, fd_cnt);
        end
        total++;
        if (fd_cyc - acc + 1 != exp_len) begin
            bad++;
            $display("FAIL frame_%h_len got=%0d want=%0d", d, fd_cyc - acc + 1, exp_len);
        end
        total++;
        if (ready_o !== 1'b1 || tx_o !== 1'b1) begin
            bad++;
            $display("FAIL frame_%h_idle got=ready%b_tx%b want=ready1_tx1", d, ready_o, tx_o);
        end
    endtask

    task automatic test_back_to_back;
        int acc1, acc2, rdy_cnt, fd_cnt, fd_cyc;
        bit ok, last_rdy;
        @(posedge clk_i); #1;
        cfg_div_i = 16'd0;
        cfg_bits_i = 2'b11;
        cfg_parity_en_i = 1'b0;
        cfg_parity_odd_i = 1'b0;
        cfg_stop2_i = 1'b1;
        data_i = 8'hA5;
        valid_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (ready_o !== 1'b1) begin bad++; $display("FAIL b2b_first_ready got=%b want=1", ready_o); end
        @(posedge clk_i); #1;
        acc1 = cyc;
        data_i = 8'h3C;
        rdy_cnt = 0;
        last_rdy = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk_i);
            last_rdy = ready_o;
            if (ready_o) rdy_cnt++;
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        acc2 = last_rdy ? cyc : -1;
        total++;
        if (rdy_cnt != 1) begin bad++; $display("FAIL b2b_ready_cycles got=%0d want=1", rdy_cnt); end
        total++;
        if (acc2 - acc1 != 11) begin bad++; $display("FAIL b2b_start_gap got=%0d want=11", acc2 - acc1); end
        wait_frame(fd_cnt, fd_cyc, ok);
        total++;
        if (!ok || fd_cyc != acc2 + 10) begin
            bad++;
            $display("FAIL b2b_second_done got=%0d want=%0d", fd_cyc, acc2 + 10);
        end
    endtask

    task automatic test_reset_mid_frame;
        int acc;
        send(8'hFF, 7, 2'b11, 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 100 && cyc < acc + 34; i++) begin
            @(posedge clk_i); #1;
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (tx_o !== 1'b1) begin bad++; $display("FAIL abort_tx got=%b want=1", tx_o); end
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy_o); end
        test_frame(8'h00, 7, 2'b11, 1'b0, 1'b0, 1'b0, 80);
    endtask

    task automatic test_cfg_change;
        int acc, fd_cnt, fd_cyc;
        bit ok;
        send(8'h96, 3, 2'b11, 1'b0, 1'b0, 1'b0, acc);
        repeat (10) @(posedge clk_i);
        #1;
        cfg_div_i = 16'd9;
        cfg_bits_i = 2'b00;
        data_i = 8'h00;
        wait_frame(fd_cnt, fd_cyc, ok);
        total++;
        if (!ok || fd_cyc - acc + 1 != 40) begin
            bad++;
            $display("FAIL cfgchg_old_len got=%0d want=40", fd_cyc - acc + 1);
        end
        test_frame(8'h5A, 9, 2'b00, 1'b0, 1'b0, 1'b0, 70);
    endtask

    initial begin
        test_reset();
        test_frame(8'h55, 3, 2'b11, 1'b0, 1'b0, 1'b0, 40);
        test_frame(8'h41, 1, 2'b10, 1'b1, 1'b0, 1'b0, 20);
        test_frame(8'h41, 1, 2'b10, 1'b1, 1'b1, 1'b0, 20);
        test_frame(8'hE7, 0, 2'b00, 1'b1, 1'b1, 1'b1, 9);
        test_back_to_back();
        test_reset_mid_frame();
        test_cfg_change();
        repeat (3) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
